ble_tx: RTL

//  UART 8N1 transmitter toward the BLE112: the return path for the command

---
 rtl/ble_pkg.sv | 18 +
 rtl/ble_tx_if.sv | 28 ++
 rtl/ble_tx_fifo.sv | 72 +++++++
 rtl/ble_tx.sv | 102 ++++++++++
 4 files changed

// File: rtl/ble_pkg.sv
// Shared definitions for the BLE112 UART link (transmitter and command receiver).
package ble_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XMIT = 1'b1
    } tx_state_t;

    // start + 8 data + stop
    localparam int FRAME_BITS         = 10;
    localparam int BAUD_DIV_50M_19200 = 2604;

    // Frame image as shifted out LSB first: start bit in [0], stop bit in [9].
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/ble_tx_if.sv
// Status-byte path from the digital core into the BLE112 transmitter.
interface ble_tx_if;

    logic       trmt;
    logic [7:0] tx_data;
    logic       fifo_full;
    logic       tx_busy;
    logic       tx_done;

    // Core side: strobes bytes in, watches queue/line status.
    modport master (
        output trmt,
        output tx_data,
        input  fifo_full,
        input  tx_busy,
        input  tx_done
    );

    // Transmitter side.
    modport slave (
        input  trmt,
        input  tx_data,
        output fifo_full,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/ble_tx_fifo.sv
// Small show-ahead byte queue feeding the UART serialiser.
module tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic       rd,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          full_reg;
    logic          wr_en;
    logic          rd_en;

    assign empty = (count_reg == '0);
    assign full  = full_reg;
    // Head is read combinationally so the FSM can load it in the pop cycle.
    assign rdata = mem[rd_ptr_reg];

    // A pop in the same cycle frees a slot, so a write on a full queue still lands.
    assign rd_en = rd && !empty;
    assign wr_en = wr && (!full_reg || rd_en);

    // Occupancy after this cycle's write/pop.
    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage entries: each slot captures wdata when the write pointer addresses it.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (wr_en && (wr_ptr_reg == AW'(gi))) begin
                    mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    // Pointers, count and registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(FIFO_DEPTH));
        end
    end

endmodule

// File: rtl/ble_tx.sv
// UART 8N1 transmitter toward the BLE112: queues status bytes and shifts them out LSB first.
module ble_tx
    import ble_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_50M_19200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    ble_tx_if.slave bus,
    output logic   TX
);

    localparam int BW = $clog2(BAUD_DIV);

    tx_state_t       state_reg, state_next;
    logic [BW-1:0]   baud_cnt_reg, baud_cnt_next;
    logic [3:0]      bit_cnt_reg, bit_cnt_next;
    logic [FRAME_BITS-1:0] shreg_reg, shreg_next;
    logic            tx_reg, tx_next;
    logic            done_reg, done_next;
    logic            pop;
    logic [7:0]      fifo_rdata;
    logic            fifo_empty;
    logic            fifo_full;

    tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (bus.trmt),
        .wdata (bus.tx_data),
        .rd    (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.fifo_full = fifo_full;
    assign bus.tx_busy   = (state_reg == XMIT);
    assign bus.tx_done   = done_reg;
    assign TX            = tx_reg;

    // Next-state logic: pop and load a frame from IDLE, then step bits every BAUD_DIV cycles.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shreg_next    = shreg_reg;
        done_next     = 1'b0;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    shreg_next    = make_frame(fifo_rdata);
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = XMIT;
                end
            end
            XMIT: begin
                if (baud_cnt_reg == BW'(BAUD_DIV - 1)) begin
                    baud_cnt_next = '0;
                    shreg_next    = {1'b1, shreg_reg[FRAME_BITS-1:1]};
                    bit_cnt_next  = bit_cnt_reg + 4'd1;
                    // Last bit period of the stop bit has elapsed.
                    if (bit_cnt_reg == 4'(FRAME_BITS - 1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Line follows the next shift register LSB so TX itself is a clean flop.
        tx_next = (state_next == XMIT) ? shreg_next[0] : 1'b1;
    end

    // State, counters, shift register and line driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shreg_reg    <= '1;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shreg_reg    <= shreg_next;
            tx_reg       <= tx_next;
            done_reg     <= done_next;
        end
    end

endmodule
